counter_bus_master: RTL

- Host-side controller and reader for a bank of loadable 8-bit counters that share one tri-state 8-bit bus.
- Accepts host commands over a valid/ready channel: read a counter, load a counter, enable or disable counting.
- Drives each counter's one-hot load, oe and en strobes, samples the shared bus, and returns one response per command.
- Guarantees at most one oe active at any time, with a dead cycle between bus owners.

---
 rtl/counter_bus_master_pkg.sv | 20 ++
 rtl/counter_bus_master_dev_decode.sv | 22 ++
 rtl/counter_bus_master.sv | 118 +++++++++++
 3 files changed

// File: rtl/counter_bus_master_pkg.sv
// Shared encodings for the counter bus master: host opcodes, FSM states, bus width.
package counter_bus_master_pkg;

    localparam int BUS_W = 8;

    typedef enum logic [1:0] {
        OP_READ   = 2'b00,
        OP_WRITE  = 2'b01,
        OP_EN_ON  = 2'b10,
        OP_EN_OFF = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_OE,
        ST_LOAD,
        ST_RESP
    } state_e;

endpackage

// File: rtl/counter_bus_master_dev_decode.sv
// Index-to-one-hot decoder with out-of-range flag. The flag is independent of
// the strobe so callers can use it to classify an index without strobing.
module dev_onehot_decode #(
    parameter int N_DEV = 4,
    parameter int DEV_W = 3
) (
    input  logic [DEV_W-1:0] idx,
    input  logic             strobe,
    output logic [N_DEV-1:0] onehot,
    output logic             oor
);

    // One bit per device; nothing is driven for an out-of-range index
    always_comb begin
        onehot = '0;
        oor    = (idx >= DEV_W'(N_DEV));
        for (int i = 0; i < N_DEV; i++) begin
            onehot[i] = strobe && !oor && (idx == DEV_W'(i));
        end
    end

endmodule

// File: rtl/counter_bus_master.sv
// Host-side controller for a bank of loadable counters on one shared bus.
// One command in flight; every command yields exactly one response.
// cmd_dev carries one bit more than needed to address N_DEV devices so that
// out-of-range indices are expressible even when N_DEV is a power of two.
module counter_bus_master
    import counter_bus_master_pkg::*;
#(
    parameter  int N_DEV  = 4,
    parameter  int SETTLE = 1,
    localparam int DEV_W  = $clog2(N_DEV) + 1
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [DEV_W-1:0] cmd_dev,
    input  logic [BUS_W-1:0] cmd_wdata,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [BUS_W-1:0] rsp_data,
    output logic             rsp_err,
    output logic [N_DEV-1:0] dev_oe,
    output logic [N_DEV-1:0] dev_load,
    output logic [N_DEV-1:0] dev_en,
    output logic [BUS_W-1:0] dev_load_val,
    input  logic [BUS_W-1:0] bus_q
);

    localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    state_e           state, state_nxt;
    logic [DEV_W-1:0] dev_q;
    logic [CNT_W-1:0] cnt;
    logic [N_DEV-1:0] dev_sel, en_hit;
    logic             q_oor, cmd_oor, acc, settle_last;
    op_e              op;

    assign op          = op_e'(cmd_op);
    assign acc         = cmd_valid && (state == ST_IDLE);
    assign settle_last = (cnt == CNT_W'(SETTLE - 1));

    // Selected device of the command in flight; q_oor also flags the error response
    dev_onehot_decode #(.N_DEV(N_DEV), .DEV_W(DEV_W)) u_sel_dec (
        .idx    (dev_q),
        .strobe (1'b1),
        .onehot (dev_sel),
        .oor    (q_oor)
    );

    // Target of the incoming command, strobed only on acceptance
    dev_onehot_decode #(.N_DEV(N_DEV), .DEV_W(DEV_W)) u_cmd_dec (
        .idx    (cmd_dev),
        .strobe (acc),
        .onehot (en_hit),
        .oor    (cmd_oor)
    );

    // State register; reset drops oe at once since oe decodes from state
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) state <= ST_IDLE;
        else         state <= state_nxt;
    end

    // Next-state: invalid devices and enable ops go straight to the response
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (acc) begin
                    if (cmd_oor)               state_nxt = ST_RESP;
                    else if (op == OP_READ)    state_nxt = ST_OE;
                    else if (op == OP_WRITE)   state_nxt = ST_LOAD;
                    else                       state_nxt = ST_RESP;
                end
            end
            ST_OE:   if (settle_last) state_nxt = ST_RESP;
            ST_LOAD: state_nxt = ST_RESP;
            ST_RESP: if (rsp_ready) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Outputs decoded from state; RESP always returns through IDLE, so oe owners never abut
    always_comb begin
        cmd_ready = (state == ST_IDLE);
        rsp_valid = (state == ST_RESP);
        dev_oe    = {N_DEV{state == ST_OE}}   & dev_sel;
        dev_load  = {N_DEV{state == ST_LOAD}} & dev_sel;
        rsp_err   = rsp_valid && q_oor;
    end

    // Command registers, settle counter and bus capture at the last OE edge
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            dev_q        <= '0;
            cnt          <= '0;
            rsp_data     <= '0;
            dev_load_val <= '0;
        end else if (acc) begin
            dev_q    <= cmd_dev;
            cnt      <= '0;
            rsp_data <= '0;
            if (op == OP_WRITE && !cmd_oor) dev_load_val <= cmd_wdata;
        end else if (state == ST_OE) begin
            cnt <= cnt + CNT_W'(1);
            if (settle_last) rsp_data <= bus_q;
        end
    end

    // Per-counter enables change only on an accepted in-range EN_ON/EN_OFF
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n)                  dev_en <= '0;
        else if (op == OP_EN_ON)      dev_en <= dev_en | en_hit;
        else if (op == OP_EN_OFF)     dev_en <= dev_en & ~en_hit;
    end

endmodule
